// File: rtl/carregador_mapa_pkg.sv
// carregador_mapa_pkg: state codes and map constants shared by the map loader units
package carregador_mapa_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECEBE  = 3'd1,
    ESCREVE = 3'd2,
    LE_END  = 3'd3,
    LE_DADO = 3'd4,
    COMPARA = 3'd5,
    FIM     = 3'd6,
    ERRO    = 3'd7
  } estado_t;
  localparam logic [3:0] ULTIMO_ENDERECO  = 4'd15;
  localparam logic [3:0] COLUNA_BLOQUEADA = 4'b1111;
endpackage

// File: rtl/carregador_mapa_contador.sv
// contador_m_16: 4-bit counter; clock, zera_as async clear, zera_s sync clear, conta enable, q count
module contador_m_16 (
  input  logic       clock,
  input  logic       zera_as,
  input  logic       zera_s,
  input  logic       conta,
  output logic [3:0] q
);
  logic [3:0] q_q, q_d;
  always_comb q_d = zera_s ? 4'd0 : conta ? q_q + 4'd1 : q_q;
  always_ff @(posedge clock or posedge zera_as)
    if (zera_as) q_q <= 4'd0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/carregador_mapa.sv
// carregador_mapa: loads 16 map columns via valid/ready into a 16x4 RAM, reads back and checks an XOR checksum; carregado/erro report the result, db_* expose state and address
module carregador_mapa
  import carregador_mapa_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar_carga,
  input  logic [3:0] dado,
  input  logic       dado_valido,
  output logic       dado_pronto,
  output logic       mem_we,
  output logic [3:0] mem_addr,
  output logic [3:0] mem_data,
  input  logic [3:0] mem_q,
  output logic       carregado,
  output logic       erro,
  output logic [3:0] db_estado,
  output logic [3:0] db_endereco
);
  estado_t estado_q, estado_d;
  logic [3:0] dado_q, dado_d, soma_escrita_q, soma_escrita_d, soma_leitura_q, soma_leitura_d;
  logic [3:0] endereco;
  logic zera, conta, ultimo;
  contador_m_16 u_contador (
    .clock  (clock),
    .zera_as(1'b0),
    .zera_s (reset | zera),
    .conta  (conta),
    .q      (endereco)
  );
  assign ultimo = endereco == ULTIMO_ENDERECO;
  always_comb begin
    estado_d       = estado_q;
    dado_d         = dado_q;
    soma_escrita_d = soma_escrita_q;
    soma_leitura_d = soma_leitura_q;
    zera           = 1'b0;
    conta          = 1'b0;
    case (estado_q)
      IDLE, FIM, ERRO:
        if (iniciar_carga) begin
          zera           = 1'b1;
          soma_escrita_d = 4'd0;
          soma_leitura_d = 4'd0;
          estado_d       = RECEBE;
        end
      RECEBE:
        if (dado_valido) begin
          if (dado == COLUNA_BLOQUEADA || (ultimo && dado != 4'd0)) estado_d = ERRO;
          else begin
            dado_d   = dado;
            estado_d = ESCREVE;
          end
        end
      ESCREVE: begin
        soma_escrita_d = soma_escrita_q ^ dado_q;
        zera           = ultimo;
        conta          = !ultimo;
        estado_d       = ultimo ? LE_END : RECEBE;
      end
      LE_END: estado_d = LE_DADO;
      LE_DADO: begin
        soma_leitura_d = soma_leitura_q ^ mem_q;
        conta          = !ultimo;
        estado_d       = ultimo ? COMPARA : LE_END;
      end
      COMPARA: estado_d = soma_leitura_q == soma_escrita_q ? FIM : ERRO;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      estado_q       <= IDLE;
      dado_q         <= 4'd0;
      soma_escrita_q <= 4'd0;
      soma_leitura_q <= 4'd0;
    end else begin
      estado_q       <= estado_d;
      dado_q         <= dado_d;
      soma_escrita_q <= soma_escrita_d;
      soma_leitura_q <= soma_leitura_d;
    end
  assign dado_pronto = estado_q == RECEBE;
  assign mem_we      = estado_q == ESCREVE;
  assign mem_addr    = endereco;
  assign mem_data    = estado_q == ESCREVE ? dado_q : 4'd0;
  assign carregado   = estado_q == FIM;
  assign erro        = estado_q == ERRO;
  assign db_estado   = {1'b0, estado_q};
  assign db_endereco = endereco;
endmodule

// File: doc/carregador_mapa.md
CARREGADOR_MAPA -- requirements
Module: carregador_mapa

Interface
REQ-001 SHALL have port clock, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port iniciar_carga, input, 1, starts a map load from IDLE, FIM or ERRO.
REQ-004 SHALL have port dado, input, 4, obstacle column for the current address; bit i=1 means obstacle in lane i.
REQ-005 SHALL have port dado_valido, input, 1, source handshake; dado is valid while high.
REQ-006 SHALL have port dado_pronto, output, 1, loader ready; a transfer occurs on a cycle with dado_valido=1 and dado_pronto=1.
REQ-007 SHALL have port mem_we, output, 1, write enable to the 16x4 map RAM.
REQ-008 SHALL have port mem_addr, output, 4, RAM address.
REQ-009 SHALL have port mem_data, output, 4, RAM write data.
REQ-010 SHALL have port mem_q, input, 4, RAM read data, valid one cycle after mem_addr is presented.
REQ-011 SHALL have port carregado, output, 1, map loaded and verified.
REQ-012 SHALL have port erro, output, 1, load rejected.
REQ-013 SHALL have port db_estado, output, 4, current state code, zero-extended.
REQ-014 SHALL have port db_endereco, output, 4, current address counter.

Function
REQ-015 SHALL implement the Moore FSM IDLE=0, RECEBE=1, ESCREVE=2, LE_END=3, LE_DADO=4, COMPARA=5, FIM=6, ERRO=7; all outputs decode from state and registers only.
REQ-016 IDLE: on iniciar_carga=1, SHALL clear endereco, soma_escrita and soma_leitura, then go to RECEBE.
REQ-017 RECEBE: dado_pronto=1; on transfer SHALL go to ERRO if dado=4'b1111 (no free lane) or if endereco=15 and dado!=0 (last column must be clear); otherwise SHALL latch dado and go to ESCREVE.
REQ-018 ESCREVE: mem_we=1, mem_addr=endereco, mem_data=latched value; SHALL XOR it into soma_escrita; if endereco=15, SHALL clear endereco and go to LE_END; otherwise SHALL increment endereco and go to RECEBE.
REQ-019 LE_END: mem_we=0, mem_addr=endereco; SHALL go to LE_DADO unconditionally.
REQ-020 LE_DADO: mem_addr held; SHALL XOR mem_q into soma_leitura; if endereco=15, SHALL go to COMPARA; otherwise SHALL increment endereco and go to LE_END.
REQ-021 COMPARA: SHALL go to FIM if soma_leitura=soma_escrita; otherwise SHALL go to ERRO.
REQ-022 FIM SHALL drive carregado=1, and ERRO SHALL drive erro=1; both states hold until iniciar_carga=1, which SHALL behave as in REQ-016.
REQ-023 In all states other than RECEBE, dado_pronto SHALL be 0 and dado_valido SHALL be ignored; in all states other than ESCREVE, mem_we SHALL be 0.
REQ-024 iniciar_carga SHALL be ignored in RECEBE through COMPARA.
REQ-025 A full clean load SHALL take 16 transfers plus 16 ESCREVE, 32 readback and 1 COMPARA cycles; with dado_valido held high this is 65 cycles from the first RECEBE to FIM.
REQ-026 Address arithmetic SHALL be 4-bit; endereco never wraps past 15 within a phase.
REQ-027 In all states other than ESCREVE, LE_END and LE_DADO, mem_addr SHALL equal endereco.

Reset
REQ-028 When reset=1 at a clock edge, the FSM SHALL enter IDLE and endereco, both checksums and the data latch SHALL be cleared.
REQ-029 After reset, every output SHALL be 0: dado_pronto, mem_we, mem_addr, mem_data, carregado, erro, db_estado and db_endereco.
REQ-030 Reset SHALL take priority over every other input, including mid-ESCREVE; mem_we SHALL be 0 from the cycle after reset is sampled.

Structure
REQ-031 State codes and constants (ULTIMO_ENDERECO=15, COLUNA_BLOQUEADA=4'b1111) SHALL live in a shared package or include used by the game units.
REQ-032 The address counter SHALL be an instance of the existing contador_m_16, with zera_as=0, zera_s driven from the FSM and conta driven from the FSM; no other sub-module.

Verification
REQ-033 Scenario: reset, iniciar_carga, columns 0x0,0x1,0x2,...,0xE then 0x0, with a RAM model -> 16 writes at addr 0..15, 32 reads, carregado=1 at cycle 65, erro=0.
REQ-034 Scenario: transfer dado=0xF at addr 5 -> ERRO, erro=1, addresses 5..15 never written.
REQ-035 Scenario: dado=0x4 at addr 15 -> ERRO and no write at address 15.
REQ-036 Scenario: RAM model corrupts addr 7 on readback (stored 0x3, read 0x2) -> COMPARA goes to ERRO, carregado=0.
REQ-037 Scenario: reset asserted in ESCREVE at addr 9 -> next cycle db_estado=0, mem_we=0, all outputs 0; a new iniciar_carga restarts from addr 0.
REQ-038 Scenario: dado_valido toggled 1/0 every cycle -> exactly 16 transfers with data in order, and a final result identical to REQ-033.
